// File: rtl/dcache_mem_ctrl.sv
// Purpose: backing-memory responder for dCache line fills and dirty-line writebacks.
// Latency: response/ack rises MEM_LATENCY cycles after a request is accepted in IDLE.
// Backpressure: four-phase level handshake; new requests are accepted only from IDLE.
// Optional feature: define DMEM_STATS_EN to build the saturating rd_count/wr_count counters.

`ifndef DCACHE_LINE_WIDTH
`define DCACHE_LINE_WIDTH 128
`endif
`ifndef MEM_ADDRESS_LEN
`define MEM_ADDRESS_LEN 32
`endif

module dcache_mem_ctrl #(
   parameter int LINE_WIDTH  = `DCACHE_LINE_WIDTH,
   parameter int ADDR_WIDTH  = `MEM_ADDRESS_LEN,
   parameter int MEM_LINES   = 256,
   parameter int MEM_LATENCY = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_dCache_mem,
   input  logic [ADDR_WIDTH-1:0] req_dCache_mem_addr,
   input  logic                  wb_req,
   input  logic [ADDR_WIDTH-1:0] wb_addr,
   input  logic [LINE_WIDTH-1:0] wb_data,
   output logic [LINE_WIDTH-1:0] data_to_fill,
   output logic                  mem_data_rdy,
   output logic                  wb_ack,
   output logic                  busy,
   output logic [15:0]           rd_count,
   output logic [15:0]           wr_count
);

   localparam int OFF_W = $clog2(LINE_WIDTH / 8);
   localparam int IDX_W = $clog2(MEM_LINES);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] WB_WAIT = 3'd1;
   localparam logic [2:0] WB_ACK  = 3'd2;
   localparam logic [2:0] RD_WAIT = 3'd3;
   localparam logic [2:0] RD_RESP = 3'd4;

   logic [2:0]            state;
   logic [15:0]           cnt;
   logic [IDX_W-1:0]      idx_q;
   logic [LINE_WIDTH-1:0] wdat_q;
   logic [LINE_WIDTH-1:0] fill_q;
   logic [IDX_W-1:0]      wb_idx;
   logic [IDX_W-1:0]      rd_idx;
   logic [LINE_WIDTH-1:0] rd_line;
   logic                  commit;
   logic                  rd_done;

   // Backing array. Lines never written still read as the power-up pattern
   // (four copies of the line number), tracked by a per-line written flag so
   // no clearing pass is needed; neither the array nor the flags see reset.
   logic [LINE_WIDTH-1:0] mem [MEM_LINES];
   logic [MEM_LINES-1:0]  written = '0;

   // Only the line-index slice of each address matters.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{req_dCache_mem_addr, wb_addr};

   assign wb_idx  = wb_addr[OFF_W +: IDX_W];
   assign rd_idx  = req_dCache_mem_addr[OFF_W +: IDX_W];
   assign rd_line = written[idx_q] ? mem[idx_q]
                                   : {(LINE_WIDTH / 32){32'(idx_q)}};
   assign commit  = (state == WB_WAIT) && (cnt == 16'd0);
   assign rd_done = (state == RD_WAIT) && (cnt == 16'd0);

   // Transaction FSM: latch request in IDLE, count down, then hold the response.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         cnt    <= '0;
         idx_q  <= '0;
         wdat_q <= '0;
         fill_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               // Writeback wins so a same-line read that follows sees new data.
               if (wb_req) begin
                  state  <= WB_WAIT;
                  cnt    <= 16'(MEM_LATENCY - 1);
                  idx_q  <= wb_idx;
                  wdat_q <= wb_data;
               end else if (req_dCache_mem) begin
                  state <= RD_WAIT;
                  cnt   <= 16'(MEM_LATENCY - 1);
                  idx_q <= rd_idx;
               end
            end
            WB_WAIT: begin
               if (cnt == 16'd0) state <= WB_ACK;
               else              cnt   <= cnt - 16'd1;
            end
            WB_ACK: begin
               if (!wb_req) state <= IDLE;
            end
            RD_WAIT: begin
               if (cnt == 16'd0) begin
                  fill_q <= rd_line;
                  state  <= RD_RESP;
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
            RD_RESP: begin
               if (!req_dCache_mem) begin
                  fill_q <= '0;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Array write commits on the edge that moves WB_WAIT into WB_ACK.
   always_ff @(posedge clk) begin
      if (commit) begin
         mem[idx_q]     <= wdat_q;
         written[idx_q] <= 1'b1;
      end
   end

   assign data_to_fill = fill_q;
   assign mem_data_rdy = (state == RD_RESP);
   assign wb_ack       = (state == WB_ACK);
   assign busy         = (state != IDLE);

`ifdef DMEM_STATS_EN
   logic [15:0] rd_cnt_q;
   logic [15:0] wr_cnt_q;

   // Saturating counts of completed reads (RD_RESP entries) and writebacks (WB_ACK entries).
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_cnt_q <= '0;
         wr_cnt_q <= '0;
      end else begin
         if (rd_done && rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
         if (commit  && wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
      end
   end

   assign rd_count = rd_cnt_q;
   assign wr_count = wr_cnt_q;
`else
   assign rd_count = 16'd0;
   assign wr_count = 16'd0;
`endif

endmodule

// File: tb/tb_dcache_mem_ctrl.sv
// Directed bench for dcache_mem_ctrl with default parameters (128-bit lines,
// 256 lines, latency 5). Expected values are hand-computed constants.
module tb_dcache_mem_ctrl;

   logic         clk = 1'b0;
   logic         reset;
   logic         req;
   logic [31:0]  req_addr;
   logic         wb_req;
   logic [31:0]  wb_addr;
   logic [127:0] wb_data;
   logic [127:0] data_to_fill;
   logic         mem_data_rdy;
   logic         wb_ack;
   logic         busy;
   logic [15:0]  rd_count;
   logic [15:0]  wr_count;

   int errors = 0;
   int checks = 0;
   int lat;

   always #5 clk = ~clk;

   dcache_mem_ctrl dut (
      .clk                 (clk),
      .reset               (reset),
      .req_dCache_mem      (req),
      .req_dCache_mem_addr (req_addr),
      .wb_req              (wb_req),
      .wb_addr             (wb_addr),
      .wb_data             (wb_data),
      .data_to_fill        (data_to_fill),
      .mem_data_rdy        (mem_data_rdy),
      .wb_ack              (wb_ack),
      .busy                (busy),
      .rd_count            (rd_count),
      .wr_count            (wr_count)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Count negedges until mem_data_rdy; lat = edges after acceptance, 99 on timeout.
   task automatic wait_rdy(output int l);
      int k;
      l = 99;
      k = 1;
      while (k <= 20 && l == 99) begin
         @(negedge clk);
         if (mem_data_rdy) l = k - 1;
         k++;
      end
   endtask

   task automatic wait_ack(output int l);
      int k;
      l = 99;
      k = 1;
      while (k <= 20 && l == 99) begin
         @(negedge clk);
         if (wb_ack) l = k - 1;
         k++;
      end
   endtask

   task automatic do_read(input string tag, input logic [31:0] a, input logic [127:0] exp);
      int l;
      @(negedge clk);
      req      = 1'b1;
      req_addr = a;
      wait_rdy(l);
      check({tag, "_lat"}, 128'(l), 128'd5);
      check({tag, "_data"}, data_to_fill, exp);
      check({tag, "_busy"}, 128'(busy), 128'd1);
      req_addr = 32'hFFFF_FFF0;
      @(negedge clk);
      check({tag, "_hold"}, data_to_fill, exp);
      req = 1'b0;
      @(negedge clk);
      check({tag, "_rdy_fall"}, 128'(mem_data_rdy), 128'd0);
      check({tag, "_data_clr"}, data_to_fill, 128'd0);
      check({tag, "_idle"}, 128'(busy), 128'd0);
   endtask

   task automatic do_write(input string tag, input logic [31:0] a, input logic [127:0] d);
      int l;
      @(negedge clk);
      wb_req  = 1'b1;
      wb_addr = a;
      wb_data = d;
      wait_ack(l);
      check({tag, "_lat"}, 128'(l), 128'd5);
      check({tag, "_no_rdy"}, 128'(mem_data_rdy), 128'd0);
      wb_data = '0;
      @(negedge clk);
      check({tag, "_ack_hold"}, 128'(wb_ack), 128'd1);
      wb_req = 1'b0;
      @(negedge clk);
      check({tag, "_ack_fall"}, 128'(wb_ack), 128'd0);
      check({tag, "_idle"}, 128'(busy), 128'd0);
   endtask

   initial begin
      logic [15:0] exp_rd;
      logic [15:0] exp_wr;
      reset    = 1'b0;
      req      = 1'b0;
      req_addr = '0;
      wb_req   = 1'b0;
      wb_addr  = '0;
      wb_data  = '0;

      // 1: reset for 3 cycles, then first read of line 3
      repeat (3) @(negedge clk);
      check("rst_busy", 128'(busy), 128'd0);
      check("rst_data", data_to_fill, 128'd0);
      reset = 1'b1;
      @(negedge clk);
      check("post_rst_busy", 128'(busy), 128'd0);
      check("post_rst_rdy", 128'(mem_data_rdy), 128'd0);
      check("post_rst_ack", 128'(wb_ack), 128'd0);
      check("post_rst_rdcnt", 128'(rd_count), 128'd0);
      check("post_rst_wrcnt", 128'(wr_count), 128'd0);
      do_read("rd30", 32'h30, 128'h00000003_00000003_00000003_00000003);

      // 4: address wrap, 0x1010 maps to line 1
      do_read("rd1010", 32'h1010, 128'h00000001_00000001_00000001_00000001);

      // 2: writeback to 0x10, read back through 0x1F
      do_write("wb10", 32'h10, 128'h0011_0101_0011_0101_0011_0101_0011_0101);
      do_read("rd1f", 32'h1F, 128'h0011_0101_0011_0101_0011_0101_0011_0101);

      // 3: simultaneous writeback and read to 0x20, writeback first
      @(negedge clk);
      wb_req   = 1'b1;
      wb_addr  = 32'h20;
      wb_data  = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
      req      = 1'b1;
      req_addr = 32'h20;
      wait_ack(lat);
      check("both_ack_lat", 128'(lat), 128'd5);
      check("both_no_rdy", 128'(mem_data_rdy), 128'd0);
      wb_req = 1'b0;
      wait_rdy(lat);
      check("both_rd_lat", 128'(lat), 128'd6);
      check("both_ack_low", 128'(wb_ack), 128'd0);
      check("both_rd_data", data_to_fill, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D);
      req = 1'b0;
      @(negedge clk);
      check("both_idle", 128'(busy), 128'd0);

      // 5: reset two cycles into WB_WAIT aborts the write
      @(negedge clk);
      wb_req  = 1'b1;
      wb_addr = 32'h40;
      wb_data = {4{32'hFFFF_FFFF}};
      repeat (3) @(negedge clk);
      check("abort_busy_before", 128'(busy), 128'd1);
      reset = 1'b0;
      #1;
      check("abort_busy", 128'(busy), 128'd0);
      check("abort_ack", 128'(wb_ack), 128'd0);
      check("abort_data", data_to_fill, 128'd0);
      repeat (3) @(negedge clk);
      wb_req = 1'b0;
      reset  = 1'b1;
      @(negedge clk);
      check("abort_rdcnt", 128'(rd_count), 128'd0);
      do_read("rd40", 32'h40, 128'h00000004_00000004_00000004_00000004);

      // 6: statistics after reset: 2 reads, 1 writeback
      do_write("wb50", 32'h50, 128'h55555555_AAAAAAAA_12345678_87654321);
      do_read("rd50", 32'h50, 128'h55555555_AAAAAAAA_12345678_87654321);
`ifdef DMEM_STATS_EN
      exp_rd = 16'd2;
      exp_wr = 16'd1;
`else
      exp_rd = 16'd0;
      exp_wr = 16'd0;
`endif
      check("rd_count", 128'(rd_count), 128'(exp_rd));
      check("wr_count", 128'(wr_count), 128'(exp_wr));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (errors=%0d checks=%0d)", errors, checks);
      $fatal(1, "timeout");
   end

endmodule
